// File: rtl/mem_stage.sv
// Y86-64 SEQ memory stage: quadword load/store over an internal byte-wide
// data memory, one byte per clock, with stat generation and start/done handshake.
module mem_stage #(
    parameter int MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  icode,
    input  logic [63:0] valE,
    input  logic [63:0] valA,
    input  logic [63:0] valP,
    input  logic        instr_valid,
    input  logic        imem_error,
    output logic [63:0] valM,
    output logic [2:0]  stat,
    output logic        busy,
    output logic        done,
    output logic [1:0]  dbgState
);
    // Handshake: start is sampled only on an edge where busy=0; busy stays high
    // from the accepting edge through the single done cycle, so a new start may
    // be presented in the cycle right after done.
    localparam int AW = $clog2(MEM_BYTES);

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [2:0]    cnt;
    logic [AW-1:0] addrQ;
    logic [63:0]   dataQ;
    logic          writeQ;
    logic [55:0]   rdBuf;
    logic [7:0]    mem [MEM_BYTES];

    logic          isWr;
    logic          isRd;
    logic          isMem;
    logic [63:0]   selAddr;
    logic [63:0]   selData;
    logic [64:0]   endAddr;
    logic          dmemErr;
    logic          access;
    logic [2:0]    nextStat;
    logic [AW-1:0] memIdx;
    logic [7:0]    memRd;

    assign dbgState = state;

    always_comb begin
        isWr     = (icode == 4'd4) || (icode == 4'd8) || (icode == 4'd10);
        isRd     = (icode == 4'd5) || (icode == 4'd9) || (icode == 4'd11);
        isMem    = isWr || isRd;
        selAddr  = ((icode == 4'd9) || (icode == 4'd11)) ? valA : valE;
        selData  = (icode == 4'd8) ? valP : valA;
        // 65-bit sum so addresses near 2^64 cannot wrap into range
        endAddr  = {1'b0, selAddr} + 65'd8;
        dmemErr  = isMem && (endAddr > 65'(MEM_BYTES));
        access   = isMem && instr_valid && !imem_error && !dmemErr;
        nextStat = STAT_AOK;
        if (imem_error || dmemErr) begin
            nextStat = STAT_ADR;
        end else if (!instr_valid) begin
            nextStat = STAT_INS;
        end else if (icode == 4'd0) begin
            nextStat = STAT_HLT;
        end
    end

    assign memIdx = addrQ + AW'(cnt);
    assign memRd  = mem[memIdx];

    // Memory contents survive reset, so the array lives in its own reset-free block.
    always_ff @(posedge clk) begin
        if (state == XFER && writeQ) begin
            mem[memIdx] <= dataQ[{cnt, 3'b000} +: 8];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= 3'd0;
            addrQ  <= '0;
            dataQ  <= 64'd0;
            writeQ <= 1'b0;
            rdBuf  <= 56'd0;
            valM   <= 64'd0;
            stat   <= STAT_AOK;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        addrQ  <= selAddr[AW-1:0];
                        dataQ  <= selData;
                        writeQ <= isWr;
                        cnt    <= 3'd0;
                        busy   <= 1'b1;
                        if (access) begin
                            state <= XFER;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                            stat  <= nextStat;
                        end
                    end
                end
                XFER: begin
                    // Shift right so byte 0 ends up in the low lane after 7 captures
                    rdBuf <= {memRd, rdBuf[55:8]};
                    cnt   <= cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        state <= DONE;
                        done  <= 1'b1;
                        stat  <= STAT_AOK;
                        if (!writeQ) begin
                            valM <= {memRd, rdBuf};
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed Y86 memory cases plus randomized transactions
// checked against a byte-array reference memory.
module tb_mem_stage;
    localparam int MB = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  icode;
    logic [63:0] valE;
    logic [63:0] valA;
    logic [63:0] valP;
    logic        instr_valid;
    logic        imem_error;
    logic [63:0] valM;
    logic [2:0]  stat;
    logic        busy;
    logic        done;
    logic [1:0]  dbgState;

    mem_stage #(.MEM_BYTES(MB)) dut (
        .clk(clk), .rst(rst), .start(start), .icode(icode),
        .valE(valE), .valA(valA), .valP(valP),
        .instr_valid(instr_valid), .imem_error(imem_error),
        .valM(valM), .stat(stat), .busy(busy), .done(done),
        .dbgState(dbgState)
    );

    always #5 clk = ~clk;

    logic [7:0]  ref_mem [MB];
    logic [63:0] exp_valm;
    logic [2:0]  exp_stat;
    int          checks = 0;
    int          errors = 0;
    logic [3:0]  icode_pool [10] = '{4'd0, 4'd4, 4'd5, 4'd8, 4'd9,
                                     4'd10, 4'd11, 4'd6, 4'd2, 4'd15};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r < 8) return 64'($urandom_range(0, MB - 8));
        if (r == 8) return 64'($urandom_range(MB - 7, MB - 1));
        return 64'hFFFF_FFFF_FFFF_FFF8 + 64'($urandom_range(0, 7));
    endfunction

    // One full transaction; inputs (and start) are scrambled while it is in flight.
    task automatic txn(input logic [3:0] ic, input logic [63:0] e, input logic [63:0] a,
                       input logic [63:0] p, input logic iv, input logic ie, input string tag);
        logic        is_wr, is_rd, err, acc;
        logic [63:0] addr, wdata;
        int          lat, exp_lat;
        is_wr = (ic == 4'd4) || (ic == 4'd8) || (ic == 4'd10);
        is_rd = (ic == 4'd5) || (ic == 4'd9) || (ic == 4'd11);
        addr  = (ic == 4'd9 || ic == 4'd11) ? a : e;
        wdata = (ic == 4'd8) ? p : a;
        err   = (is_wr || is_rd) && (addr > 64'(MB - 8));
        acc   = (is_wr || is_rd) && iv && !ie && !err;
        if (ie || err)    exp_stat = 3'd3;
        else if (!iv)     exp_stat = 3'd4;
        else if (ic == 0) exp_stat = 3'd2;
        else              exp_stat = 3'd1;
        exp_lat = acc ? 9 : 1;
        if (acc && is_rd) begin
            for (int i = 0; i < 8; i++) exp_valm[8*i +: 8] = ref_mem[int'(addr) + i];
        end
        if (acc && is_wr) begin
            for (int i = 0; i < 8; i++) ref_mem[int'(addr) + i] = wdata[8*i +: 8];
        end

        @(negedge clk);
        icode = ic; valE = e; valA = a; valP = p;
        instr_valid = iv; imem_error = ie; start = 1'b1;
        @(posedge clk);
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (done) begin
                lat = i;
                break;
            end
            start       = 1'($urandom_range(0, 1));
            icode       = 4'($urandom);
            valE        = {$urandom, $urandom};
            valA        = {$urandom, $urandom};
            valP        = {$urandom, $urandom};
            instr_valid = 1'($urandom);
            imem_error  = 1'($urandom);
        end
        start = 1'b0;
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " stat"}, 64'(stat), 64'(exp_stat));
        check({tag, " valM"}, valM, exp_valm);
        check({tag, " busy"}, 64'(busy), 64'd1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; icode = 4'd0; valE = 64'd0; valA = 64'd0;
        valP = 64'd0; instr_valid = 1'b1; imem_error = 1'b0;
        exp_valm = 64'd0; exp_stat = 3'd1;
        #12;
        check("reset valM", valM, 64'd0);
        check("reset stat", 64'(stat), 64'd1);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset state", 64'(dbgState), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int ad = 0; ad < MB; ad += 8)
            txn(4'd4, 64'(ad), {$urandom, $urandom}, 64'd0, 1'b1, 1'b0, "init");

        txn(4'd4, 64'h10, 64'h1122334455667788, 64'd0, 1'b1, 1'b0, "rmmovq");
        txn(4'd5, 64'h10, 64'd0, 64'd0, 1'b1, 1'b0, "mrmovq");
        check("mrmovq const", valM, 64'h1122334455667788);
        txn(4'd5, 64'h10, 64'd0, 64'd0, 1'b1, 1'b0, "reread");
        check("byte 0x10", 64'(valM[7:0]), 64'h88);

        txn(4'd8, 64'h3F8, 64'd0, 64'h2A, 1'b1, 1'b0, "call");
        txn(4'd9, 64'd0, 64'h3F8, 64'd0, 1'b1, 1'b0, "ret");
        check("ret const", valM, 64'h2A);

        txn(4'd5, 64'h3F9, 64'd0, 64'd0, 1'b1, 1'b0, "mrmovq oob");
        txn(4'd10, 64'hFFFF_FFFF_FFFF_FFFC, 64'hDEAD_BEEF_0BAD_F00D, 64'd0, 1'b1, 1'b0, "pushq wrap");
        txn(4'd5, 64'h0, 64'd0, 64'd0, 1'b1, 1'b0, "read 0");

        txn(4'd6, 64'h20, 64'h5, 64'd0, 1'b1, 1'b0, "opq");
        txn(4'd0, 64'h0, 64'h0, 64'd0, 1'b1, 1'b0, "halt");
        txn(4'd4, 64'h18, 64'h1234, 64'd0, 1'b0, 1'b0, "ins");
        txn(4'd5, 64'h18, 64'd0, 64'd0, 1'b1, 1'b0, "ins nowrite");
        txn(4'd5, 64'h18, 64'd0, 64'd0, 1'b1, 1'b1, "imem err");

        txn(4'd4, 64'h40, 64'd0, 64'd0, 1'b1, 1'b0, "zero 0x40");
        @(negedge clk);
        icode = 4'd4; valE = 64'h40; valA = 64'hAAAA_AAAA_AAAA_AAAA;
        instr_valid = 1'b1; imem_error = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("abort busy", 64'(busy), 64'd0);
        check("abort done", 64'(done), 64'd0);
        check("abort stat", 64'(stat), 64'd1);
        check("abort valM", valM, 64'd0);
        for (int i = 0; i < 3; i++) ref_mem[64 + i] = 8'hAA;
        exp_valm = 64'd0;
        @(negedge clk);
        rst = 1'b0;
        txn(4'd5, 64'h40, 64'd0, 64'd0, 1'b1, 1'b0, "read 0x40");
        check("partial write", valM, 64'h0000_0000_00AA_AAAA);

        for (int n = 0; n < 80; n++) begin
            txn(icode_pool[$urandom_range(0, 9)], rand_addr(), rand_addr(),
                {$urandom, $urandom}, ($urandom_range(0, 9) != 0),
                ($urandom_range(0, 9) == 0), "random");
            if ($urandom_range(0, 3) == 0)
                txn(4'd5, 64'($urandom_range(0, MB - 8)), 64'd0, 64'd0, 1'b1, 1'b0, "probe");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory stage of the Y86-64 SEQ datapath, directly downstream of the execute stage. It takes `valE` (ALU result / effective address), `valA`, `valP` and `icode`, performs the quadword data-memory access the instruction requires, and returns `valM` plus the instruction status `stat`. Data memory is an internal byte-wide array accessed one byte per clock. Every access is therefore a multi-cycle transaction under a start/done handshake.

## Interface
- `MEM_BYTES`, 1024: data memory size in bytes; valid addresses are 0 .. MEM_BYTES-1.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin transaction; sampled only when `busy`=0.
- `icode`  in  4  instruction code: 0 halt, 4 rmmovq, 5 mrmovq, 8 call, 9 ret, 10 pushq, 11 popq; any other value is a non-memory instruction.
- `valE`  in  64  execute-stage result.
- `valA`  in  64  register operand A.
- `valP`  in  64  incremented PC.
- `instr_valid`  in  1  fetch decoded a legal instruction.
- `imem_error`  in  1  fetch address fault.
- `valM`  out  64  data read from memory.
- `stat`  out  3  status: 1 AOK, 2 HLT, 3 ADR, 4 INS.
- `busy`  out  1  transaction in progress.
- `done`  out  1  one-cycle completion pulse.

## Operation
- Inputs are latched at the accepting edge; later input changes have no effect on the transaction in flight.
- Address selection:
  - icode 4, 5, 8, 10: address = `valE`.
  - icode 9, 11: address = `valA`.
- Memory writes:
  - icode 4, 10 write `valA`.
  - icode 8 writes `valP`.
- Memory reads: icode 5, 9, 11.
- All other icodes perform no access.
- Quadword layout is little-endian: byte i of the word (i = 0..7) lives at address+i, and `valM[8i+7:8i]` = mem[address+i].
- `dmem_error` is asserted for a memory icode when address+8 > `MEM_BYTES`.
  - The comparison is computed at 65-bit width, so addresses within 7 of 2^64 (wrap-around) are errors.
  - On `dmem_error` there is no access: no byte is written and `valM` is not updated.
- No access is made when `imem_error`=1 or `instr_valid`=0.
- `stat` priority, highest first:
  - ADR if `imem_error` or `dmem_error`.
  - else INS if `instr_valid`=0.
  - else HLT if icode=0.
  - else AOK.
- FSM states:
  - IDLE: `busy`=0. On `start`, latch the inputs. Go to XFER if a legal access is required; otherwise go to DONE.
  - XFER: byte counter `cnt` runs 0..7. Each edge writes byte `cnt`, or captures mem[address+cnt] into the read buffer, then increments `cnt`. The edge with `cnt`=7 goes to DONE.
  - DONE: `done`=1 and `busy`=1. `stat` is updated. On reads, `valM` is loaded from the read buffer. The next edge always returns to IDLE.
- `valM` and `stat` hold their values until the next DONE.
- Memory contents are not cleared by reset.

## Timing
- Reset (async, immediate) puts the FSM in IDLE and forces:
  - `valM`=0, `stat`=1 (AOK), `busy`=0, `done`=0, `cnt`=0.
- Latency is counted from the edge E0 that samples `start`:
  - Memory access: XFER covers edges E1..E8; `done` is high in the cycle after E8, i.e. 9 cycles after E0.
  - Non-memory or error: `done` is high in the cycle after E0.
- `busy` rises after E0 and falls at the edge that leaves DONE.
- Back-to-back transactions: `start` may be asserted again in the cycle immediately after DONE.
- `start` is ignored while `busy`=1.
- Reset during XFER aborts the transaction:
  - Bytes already written remain modified.
  - No `done` pulse is produced.
  - `stat` returns to AOK.
- Reads in XFER use the array contents as they were before that edge's write. No transaction reads and writes the same location.

## Test plan
- rmmovq then mrmovq round-trip (MEM_BYTES=1024):
  - Stimulus: icode 4, `valE`=0x10, `valA`=0x1122334455667788; then icode 5, `valE`=0x10.
  - Response: each transaction gives `done` 9 cycles after start with `stat`=1; the read returns `valM`=0x1122334455667788.
  - A second read at `valE`=0x10 with only byte 0x10 checked confirms mem[0x10]=0x88 (little-endian).
- call/ret round-trip:
  - Stimulus: icode 8, `valE`=0x3F8, `valP`=0x2A; then icode 9, `valA`=0x3F8.
  - Response: `valM`=0x000000000000002A, `stat`=1.
- Address errors:
  - Stimulus: icode 5, `valE`=0x3F9.
  - Response: `done` 1 cycle after start, `stat`=3, `valM` unchanged.
  - Stimulus: icode 10, `valE`=0xFFFFFFFFFFFFFFFC.
  - Response: `stat`=3, and a follow-up read of 0x0 shows no bytes changed.
- Non-memory and status cases, each giving `done` 1 cycle after start:
  - icode 6 gives `stat`=1.
  - icode 0 gives `stat`=2.
  - icode 4 with `instr_valid`=0 gives `stat`=4 and no write.
  - `imem_error`=1 gives `stat`=3.
- Handshake: assert `start` with new inputs during XFER.
  - Response: ignored; the original transaction completes unchanged.
- Reset mid-write:
  - Stimulus: icode 4, `valE`=0x40, `valA`=0xAAAAAAAAAAAAAAAA over memory previously set to 0; assert `rst` after 3 XFER edges.
  - Response: `busy`=0, `done`=0, `stat`=1 immediately. A subsequent read of 0x40 returns 0x0000000000AAAAAA.
